// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped machine timer: register offsets,
// CTRL layout, reset constants and the byte-enable merge helper.
package timer_pkg;

  localparam int TIMER_MTIME_LO    = 'h00;
  localparam int TIMER_MTIME_HI    = 'h04;
  localparam int TIMER_MTIMECMP_LO = 'h08;
  localparam int TIMER_MTIMECMP_HI = 'h0C;
  localparam int TIMER_CTRL        = 'h10;

  localparam int CTRL_EN_BIT         = 0;
  localparam int CTRL_IRQ_EN_BIT     = 1;
  localparam int CTRL_PRESCALE_LSB   = 8;
  localparam int CTRL_PRESCALE_MAX_W = 24;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // 32-bit view of CTRL; PRESCALE occupies the low PrescaleWidth bits of the field.
  typedef struct packed {
    logic [CTRL_PRESCALE_MAX_W-1:0] prescale;
    logic [5:0]                     rsvd;
    logic                           irq_en;
    logic                           en;
  } ctrl_t;

  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the machine timer: counts 0..prescale while enabled and
// pulses tick_o in the cycle the count equals prescale.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PrescaleWidth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     clear_i,
  input  logic [PrescaleWidth-1:0] prescale_i,
  output logic                     tick_o
);

  logic [PrescaleWidth-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == prescale_i);

  // Clear wins over the wrap so a CTRL write always restarts the period.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + PrescaleWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_timer.sv
// RISC-V machine timer (mtime/mtimecmp) on a bus device port: register file,
// address decode, one-cycle response path and level timer interrupt.
module bus_timer
  import timer_pkg::*;
#(
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int RegAddrWidth  = 10,
  parameter int PrescaleWidth = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    device_req_i,
  input  logic [AddressWidth-1:0] device_addr_i,
  input  logic                    device_we_i,
  input  logic [3:0]              device_be_i,
  input  logic [DataWidth-1:0]    device_wdata_i,
  output logic                    device_rvalid_o,
  output logic [DataWidth-1:0]    device_rdata_o,
  output logic                    device_err_o,
  output logic                    timer_irq_o
);

  // Handshake: the device never stalls; every device_req_i cycle yields exactly
  // one device_rvalid_o pulse on the next cycle, with rdata/err valid alongside.

  logic [RegAddrWidth-1:0] reg_off;
  logic sel_mtime_lo, sel_mtime_hi, sel_cmp_lo, sel_cmp_hi, sel_ctrl, hit;
  logic rd, wr, tick;

  logic [63:0]              mtime_q, mtime_d;
  logic [63:0]              mtimecmp_q, mtimecmp_d;
  logic [31:0]              shadow_q, shadow_d;
  logic                     en_q, en_d, irq_en_q, irq_en_d;
  logic [PrescaleWidth-1:0] prescale_q, prescale_d;
  logic                     rvalid_q, err_q, irq_q;
  logic [DataWidth-1:0]     rdata_q, rdata_d;
  logic                     err_d, irq_d;
  ctrl_t                    ctrl_rd, ctrl_wr;
  logic                     unused_addr, unused_ctrl;

  assign reg_off      = {device_addr_i[RegAddrWidth-1:2], 2'b00};
  assign sel_mtime_lo = (reg_off == RegAddrWidth'(TIMER_MTIME_LO));
  assign sel_mtime_hi = (reg_off == RegAddrWidth'(TIMER_MTIME_HI));
  assign sel_cmp_lo   = (reg_off == RegAddrWidth'(TIMER_MTIMECMP_LO));
  assign sel_cmp_hi   = (reg_off == RegAddrWidth'(TIMER_MTIMECMP_HI));
  assign sel_ctrl     = (reg_off == RegAddrWidth'(TIMER_CTRL));
  assign hit = sel_mtime_lo | sel_mtime_hi | sel_cmp_lo | sel_cmp_hi | sel_ctrl;
  assign rd  = device_req_i & ~device_we_i & hit;
  assign wr  = device_req_i &  device_we_i & hit;

  assign unused_addr = ^{device_addr_i[AddressWidth-1:RegAddrWidth], device_addr_i[1:0]};
  assign unused_ctrl = ^{ctrl_wr.prescale[CTRL_PRESCALE_MAX_W-1:PrescaleWidth], ctrl_wr.rsvd};

  always_comb begin
    ctrl_rd          = '0;
    ctrl_rd.en       = en_q;
    ctrl_rd.irq_en   = irq_en_q;
    ctrl_rd.prescale = CTRL_PRESCALE_MAX_W'(prescale_q);
  end

  assign ctrl_wr = ctrl_t'(apply_be(ctrl_rd, device_wdata_i, device_be_i));

  timer_prescaler #(
    .PrescaleWidth(PrescaleWidth)
  ) u_prescaler (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (en_q),
    .clear_i   (wr & sel_ctrl),
    .prescale_i(prescale_q),
    .tick_o    (tick)
  );

  always_comb begin
    rdata_d = '0;
    if (rd) begin
      if (sel_mtime_lo)      rdata_d = mtime_q[31:0];
      else if (sel_mtime_hi) rdata_d = shadow_q;
      else if (sel_cmp_lo)   rdata_d = mtimecmp_q[31:0];
      else if (sel_cmp_hi)   rdata_d = mtimecmp_q[63:32];
      else                   rdata_d = ctrl_rd;
    end
  end

  // A software write to either mtime half replaces that cycle's increment.
  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    shadow_d   = shadow_q;
    en_d       = en_q;
    irq_en_d   = irq_en_q;
    prescale_d = prescale_q;
    if (wr && sel_mtime_lo) begin
      mtime_d[31:0] = apply_be(mtime_q[31:0], device_wdata_i, device_be_i);
    end else if (wr && sel_mtime_hi) begin
      mtime_d[63:32] = apply_be(mtime_q[63:32], device_wdata_i, device_be_i);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
    if (wr && sel_cmp_lo) mtimecmp_d[31:0]  = apply_be(mtimecmp_q[31:0], device_wdata_i, device_be_i);
    if (wr && sel_cmp_hi) mtimecmp_d[63:32] = apply_be(mtimecmp_q[63:32], device_wdata_i, device_be_i);
    if (wr && sel_ctrl) begin
      en_d       = ctrl_wr.en;
      irq_en_d   = ctrl_wr.irq_en;
      prescale_d = ctrl_wr.prescale[PrescaleWidth-1:0];
    end
    if (rd && sel_mtime_lo) shadow_d = mtime_q[63:32];
  end

  assign err_d = device_req_i & ~hit;
  assign irq_d = irq_en_q & (mtime_q >= mtimecmp_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime_q    <= '0;
      mtimecmp_q <= MTIMECMP_RST;
      shadow_q   <= '0;
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      prescale_q <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      shadow_q   <= shadow_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      prescale_q <= prescale_d;
      rvalid_q   <= device_req_i;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      irq_q      <= irq_d;
    end
  end

  assign device_rvalid_o = rvalid_q;
  assign device_rdata_o  = rdata_q;
  assign device_err_o    = err_q;
  assign timer_irq_o     = irq_q;

endmodule
